// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the mini crypto processor: sequences fetch/decode/execute,
// waits on memory and crypto-unit handshakes under a watchdog, and counts retired instructions.
module multicycle_ctrl #(
  parameter int unsigned    OPW      = 4,
  parameter logic [OPW-1:0] OP_LOAD  = OPW'('h3),
  parameter logic [OPW-1:0] OP_STORE = OPW'('h4),
  parameter logic [OPW-1:0] OP_XOP   = OPW'('h8),
  parameter logic [OPW-1:0] OP_HALT  = OPW'('hF),
  parameter int unsigned    TMO      = 16,
  parameter int unsigned    CNTW     = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OPW-1:0]  opcode,
  input  logic            mem_ready,
  input  logic            alu_done,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            alu_enable,
  output logic            alu_start,
  output logic            pc_enable,
  output logic            halt,
  output logic            error,
  output logic [2:0]      state,
  output logic [CNTW-1:0] retired
);

  // Watchdog counter only needs to reach TMO-1.
  localparam int unsigned    WW   = (TMO > 2) ? $clog2(TMO) : 1;
  localparam logic [WW-1:0] WLIM = WW'((TMO == 0) ? 0 : TMO - 1);

  typedef enum logic [2:0] {
    StFetch     = 3'd0,
    StDecode    = 3'd1,
    StExecute   = 3'd2,
    StMem       = 3'd3,
    StWriteback = 3'd4,
    StHalt      = 3'd5,
    StError     = 3'd6,
    StXwait     = 3'd7
  } state_e;

  state_e         state_q;
  logic [OPW-1:0] op_q;
  logic [WW-1:0]  wdog_q;
  logic [CNTW-1:0] retired_q;

  logic op_is_mem;
  logic op_is_xop;
  logic op_is_halt;
  logic wdog_expired;

  assign op_is_mem    = (op_q == OP_LOAD) || (op_q == OP_STORE);
  assign op_is_xop    = (op_q == OP_XOP);
  assign op_is_halt   = (op_q == OP_HALT);
  assign wdog_expired = (TMO != 0) && (wdog_q == WLIM);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFetch;
      op_q      <= '0;
      wdog_q    <= '0;
      retired_q <= '0;
    end else begin
      case (state_q)
        StFetch:  state_q <= StDecode;
        StDecode: begin
          op_q    <= opcode;
          state_q <= StExecute;
        end
        StExecute: begin
          wdog_q <= '0;
          if (op_is_mem)       state_q <= StMem;
          else if (op_is_xop)  state_q <= StXwait;
          else if (op_is_halt) state_q <= StHalt;
          else                 state_q <= StWriteback;
        end
        // Handshake is checked first so it wins against a simultaneous expiry.
        StMem: begin
          if (mem_ready)         state_q <= StWriteback;
          else if (wdog_expired) state_q <= StError;
          else                   wdog_q  <= wdog_q + WW'(1);
        end
        StXwait: begin
          if (alu_done)          state_q <= StWriteback;
          else if (wdog_expired) state_q <= StError;
          else                   wdog_q  <= wdog_q + WW'(1);
        end
        StWriteback: begin
          retired_q <= retired_q + CNTW'(1);
          state_q   <= StFetch;
        end
        StHalt:  state_q <= StHalt;
        StError: state_q <= StError;
        default: state_q <= StFetch;
      endcase
    end
  end

  assign pc_enable  = (state_q == StFetch);
  assign alu_enable = (state_q == StExecute) && !op_is_mem && !op_is_xop && !op_is_halt;
  assign alu_start  = (state_q == StExecute) && op_is_xop;
  assign mem_read   = (state_q == StMem) && (op_q == OP_LOAD);
  assign mem_write  = (state_q == StMem) && (op_q == OP_STORE);
  assign reg_write  = (state_q == StWriteback) && (op_q != OP_STORE);
  assign halt       = (state_q == StHalt);
  assign error      = (state_q == StError);
  assign state      = state_q;
  assign retired    = retired_q;

endmodule
